// File: rtl/vga_pkg.sv
// Shared VGA-path definitions: screen geometry, erase colour, rectangle record
// and the redraw scheduler state encoding.
package vga_pkg;

  localparam int unsigned SCR_W     = 160;
  localparam int unsigned SCR_H     = 120;
  localparam logic [2:0]  BG_COLOUR = 3'b000;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [4:0] w;
    logic [4:0] h;
    logic [2:0] c;
  } rect_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_ERASE_REQ,
    S_ERASE_WAIT,
    S_DRAW_REQ,
    S_DRAW_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

endpackage

// File: rtl/obj_table.sv
// Object storage for the redraw scheduler: staging table (host writes),
// per-frame working snapshot, and shadow of last drawn geometry with drawn flags.
module obj_table
  import vga_pkg::*;
#(
  parameter int unsigned NUM_OBJ = 4,
  parameter int unsigned IW      = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_valid,
  input  rect_t         wr_obj,
  input  logic          snap,
  input  logic [IW-1:0] rd_idx,
  input  logic          rd_staging,
  output logic          rd_valid,
  output rect_t         rd_obj,
  output logic          rd_drawn,
  output rect_t         rd_shadow,
  input  logic          sh_set,
  input  logic          sh_clr,
  input  logic [IW-1:0] sh_idx,
  input  rect_t         sh_obj
);

  rect_t              stg_obj  [NUM_OBJ];
  rect_t              work_obj [NUM_OBJ];
  rect_t              shadow   [NUM_OBJ];
  logic [NUM_OBJ-1:0] stg_valid;
  logic [NUM_OBJ-1:0] work_valid;
  logic [NUM_OBJ-1:0] drawn;

  // Geometry payload needs no reset; only the valid/drawn flags gate its use.
  always_ff @(posedge clk) begin
    if (we)
      stg_obj[wr_idx] <= wr_obj;
    if (snap)
      work_obj <= stg_obj;
    if (sh_set)
      shadow[sh_idx] <= sh_obj;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stg_valid  <= '0;
      work_valid <= '0;
      drawn      <= '0;
    end else begin
      if (we)
        stg_valid[wr_idx] <= wr_valid;
      if (snap)
        work_valid <= stg_valid;
      if (sh_set)
        drawn[sh_idx] <= 1'b1;
      if (sh_clr)
        drawn[sh_idx] <= 1'b0;
    end
  end

  assign rd_valid  = rd_staging ? stg_valid[rd_idx] : work_valid[rd_idx];
  assign rd_obj    = rd_staging ? stg_obj[rd_idx]   : work_obj[rd_idx];
  assign rd_drawn  = drawn[rd_idx];
  assign rd_shadow = shadow[rd_idx];

endmodule

// File: rtl/render_scheduler.sv
// Per-frame sprite redraw sequencer: erases each previously drawn rectangle,
// then draws each valid (clipped) rectangle, one rasteriser handshake at a time.
module render_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned NUM_OBJ   = 4,
  parameter logic [2:0]  BG_COLOUR = vga_pkg::BG_COLOUR,
  parameter int unsigned SCR_W     = vga_pkg::SCR_W,
  parameter int unsigned SCR_H     = vga_pkg::SCR_H,
  localparam int unsigned IW       = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic          obj_we,
  input  logic [IW-1:0] obj_idx,
  input  logic          obj_valid,
  input  logic [7:0]    obj_x,
  input  logic [6:0]    obj_y,
  input  logic [4:0]    obj_w,
  input  logic [4:0]    obj_h,
  input  logic [2:0]    obj_c,
  output logic          rect_start,
  output logic [7:0]    rect_x,
  output logic [6:0]    rect_y,
  output logic [4:0]    rect_w,
  output logic [4:0]    rect_h,
  output logic [2:0]    rect_c,
  input  logic          rect_done,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_drop
);

  localparam logic [IW-1:0] LAST = IW'(NUM_OBJ - 1);
  localparam logic [8:0]    SW9  = 9'(SCR_W);
  localparam logic [8:0]    SH9  = 9'(SCR_H);

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] la_idx;
  rect_t         req;
  rect_t         rd_obj;
  rect_t         rd_shadow;
  rect_t         draw_rect;
  rect_t         erase_rect;
  logic          rd_valid;
  logic          rd_drawn;
  logic          draw_ok;
  logic [8:0]    rem_w;
  logic [8:0]    rem_h;

  obj_table #(
    .NUM_OBJ(NUM_OBJ),
    .IW     (IW)
  ) u_obj_table (
    .clk       (clk),
    .reset     (reset),
    .we        (obj_we),
    .wr_idx    (obj_idx),
    .wr_valid  (obj_valid),
    .wr_obj    ({obj_x, obj_y, obj_w, obj_h, obj_c}),
    .snap      (state == S_LATCH),
    .rd_idx    (la_idx),
    .rd_staging(state == S_LATCH),
    .rd_valid  (rd_valid),
    .rd_obj    (rd_obj),
    .rd_drawn  (rd_drawn),
    .rd_shadow (rd_shadow),
    .sh_set    (state == S_DRAW_WAIT && rect_done),
    .sh_clr    (state == S_ERASE_WAIT && rect_done),
    .sh_idx    (idx),
    .sh_obj    (req)
  );

  // Requests are registered, so each slot's request is prepared on the edge that
  // enters its REQ state. From LATCH the snapshot is not yet loaded, so slot 0 is
  // read straight from staging (the same pre-write value the snapshot captures).
  always_comb begin
    la_idx = idx;
    if (state == S_LATCH)
      la_idx = '0;
    else if (state == S_NEXT && idx != LAST)
      la_idx = idx + 1'b1;
  end

  always_comb begin
    rem_w       = SW9 - {1'b0, rd_obj.x};
    rem_h       = SH9 - {2'b0, rd_obj.y};
    draw_ok     = rd_valid && (rd_obj.w != '0) && (rd_obj.h != '0) &&
                  ({1'b0, rd_obj.x} < SW9) && ({2'b0, rd_obj.y} < SH9);
    draw_rect   = rd_obj;
    if ({4'b0, rd_obj.w} > rem_w)
      draw_rect.w = rem_w[4:0];
    if ({4'b0, rd_obj.h} > rem_h)
      draw_rect.h = rem_h[4:0];
    erase_rect   = rd_shadow;
    erase_rect.c = BG_COLOUR;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      req        <= '0;
      rect_start <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      rect_start <= 1'b0;
      frame_done <= 1'b0;
      frame_drop <= frame_tick && (state != S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (frame_tick) begin
            state <= S_LATCH;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        S_LATCH, S_NEXT: begin
          if (state == S_NEXT && idx == LAST) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
          end else begin
            idx <= la_idx;
            if (rd_drawn) begin
              state      <= S_ERASE_REQ;
              rect_start <= 1'b1;
              req        <= erase_rect;
            end else begin
              state <= S_DRAW_REQ;
              if (draw_ok) begin
                rect_start <= 1'b1;
                req        <= draw_rect;
              end
            end
          end
        end
        S_ERASE_REQ: state <= S_ERASE_WAIT;
        S_ERASE_WAIT: begin
          if (rect_done) begin
            state <= S_DRAW_REQ;
            if (draw_ok) begin
              rect_start <= 1'b1;
              req        <= draw_rect;
            end
          end
        end
        S_DRAW_REQ: state <= rect_start ? S_DRAW_WAIT : S_NEXT;
        S_DRAW_WAIT: begin
          if (rect_done)
            state <= S_NEXT;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rect_x = req.x;
  assign rect_y = req.y;
  assign rect_w = req.w;
  assign rect_h = req.h;
  assign rect_c = req.c;

endmodule
